// File: rtl/mouse_frame_ctl.sv
// Frame-synchronous mouse controller: captures position/button on vblank rise,
// clamps to the screen and emits left-button clicks on a valid/ready channel.
// Optional button debounce is enabled with the MOUSE_DEBOUNCE_EN macro.
module mouse_frame_ctl #(
    parameter int unsigned H_MAX           = 1023,
    parameter int unsigned V_MAX           = 767,
    parameter int unsigned DEBOUNCE_FRAMES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblank_in,
    input  logic [11:0] xpos_in,
    input  logic [11:0] ypos_in,
    input  logic        mouseleft_in,
    output logic [11:0] xpos_out,
    output logic [11:0] ypos_out,
    output logic        mouseleft_out,
    output logic        frame_tick,
    output logic        click_valid,
    input  logic        click_ready,
    output logic [11:0] click_x,
    output logic [11:0] click_y,
    output logic        click_overrun
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    localparam logic [11:0] LP_H_MAX = 12'(H_MAX);
    localparam logic [11:0] LP_V_MAX = 12'(V_MAX);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_vblank_q;
    logic        w_rise;
    logic [11:0] r_x_raw;
    logic [11:0] r_y_raw;
    logic        r_btn_raw;
    logic [11:0] w_x_raw_nxt;
    logic [11:0] w_y_raw_nxt;
    logic        w_btn_raw_nxt;
    logic [11:0] w_x_clamp;
    logic [11:0] w_y_clamp;
    logic        w_acc_lvl;

    logic [11:0] r_xpos;
    logic [11:0] r_ypos;
    logic        r_mouseleft;
    logic        r_frame_tick;
    logic        r_click_valid;
    logic [11:0] r_click_x;
    logic [11:0] r_click_y;
    logic        r_click_overrun;

    logic [11:0] w_xpos_nxt;
    logic [11:0] w_ypos_nxt;
    logic        w_mouseleft_nxt;
    logic        w_frame_tick_nxt;
    logic        w_click_valid_nxt;
    logic [11:0] w_click_x_nxt;
    logic [11:0] w_click_y_nxt;
    logic        w_click_overrun_nxt;

    assign w_rise    = vblank_in & ~r_vblank_q;
    assign w_x_clamp = (r_x_raw > LP_H_MAX) ? LP_H_MAX : r_x_raw;
    assign w_y_clamp = (r_y_raw > LP_V_MAX) ? LP_V_MAX : r_y_raw;

`ifdef MOUSE_DEBOUNCE_EN
    localparam int unsigned LP_CNT_RAW  = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int unsigned LP_CNT_W    = (LP_CNT_RAW < 2) ? 2 : ((LP_CNT_RAW > 8) ? 8 : LP_CNT_RAW);
    localparam int unsigned LP_FRAMES   = (DEBOUNCE_FRAMES == 0) ? 1 : DEBOUNCE_FRAMES;
    localparam logic [LP_CNT_W-1:0] LP_CNT_LAST = LP_CNT_W'(LP_FRAMES - 1);

    logic [LP_CNT_W-1:0] r_db_cnt;
    logic [LP_CNT_W-1:0] w_db_cnt_nxt;

    // Debounce: the accepted level flips only after enough disagreeing captures in a row.
    always_comb begin
        w_acc_lvl    = r_mouseleft;
        w_db_cnt_nxt = r_db_cnt;
        if (r_state == ST_CAPTURE) begin
            if (r_btn_raw == r_mouseleft) begin
                w_db_cnt_nxt = '0;
            end else if (r_db_cnt >= LP_CNT_LAST) begin
                w_acc_lvl    = r_btn_raw;
                w_db_cnt_nxt = '0;
            end else begin
                w_db_cnt_nxt = r_db_cnt + LP_CNT_W'(1);
            end
        end else begin
            w_db_cnt_nxt = r_db_cnt;
        end
    end

    // Debounce counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= w_db_cnt_nxt;
        end
    end
`else
    assign w_acc_lvl = r_btn_raw;
`endif

    // Next-state and next-output logic; every register holds unless the FSM says otherwise.
    always_comb begin
        w_state_nxt         = r_state;
        w_x_raw_nxt         = r_x_raw;
        w_y_raw_nxt         = r_y_raw;
        w_btn_raw_nxt       = r_btn_raw;
        w_xpos_nxt          = r_xpos;
        w_ypos_nxt          = r_ypos;
        w_mouseleft_nxt     = r_mouseleft;
        w_frame_tick_nxt    = 1'b0;
        w_click_x_nxt       = r_click_x;
        w_click_y_nxt       = r_click_y;
        w_click_overrun_nxt = r_click_overrun;
        if (r_click_valid && click_ready) begin
            w_click_valid_nxt = 1'b0;
        end else begin
            w_click_valid_nxt = r_click_valid;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_x_raw_nxt   = xpos_in;
                    w_y_raw_nxt   = ypos_in;
                    w_btn_raw_nxt = mouseleft_in;
                    w_state_nxt   = ST_CAPTURE;
                end else begin
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                w_xpos_nxt       = w_x_clamp;
                w_ypos_nxt       = w_y_clamp;
                w_mouseleft_nxt  = w_acc_lvl;
                w_frame_tick_nxt = 1'b1;
                w_state_nxt      = ST_IDLE;
                // A press while an unaccepted event is pending is dropped and flagged.
                if (w_acc_lvl && !r_mouseleft) begin
                    if (!r_click_valid || click_ready) begin
                        w_click_valid_nxt = 1'b1;
                        w_click_x_nxt     = w_x_clamp;
                        w_click_y_nxt     = w_y_clamp;
                    end else begin
                        w_click_overrun_nxt = 1'b1;
                    end
                end else begin
                    w_click_overrun_nxt = r_click_overrun;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, capture and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_vblank_q      <= 1'b0;
            r_x_raw         <= 12'd0;
            r_y_raw         <= 12'd0;
            r_btn_raw       <= 1'b0;
            r_xpos          <= 12'd0;
            r_ypos          <= 12'd0;
            r_mouseleft     <= 1'b0;
            r_frame_tick    <= 1'b0;
            r_click_valid   <= 1'b0;
            r_click_x       <= 12'd0;
            r_click_y       <= 12'd0;
            r_click_overrun <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_vblank_q      <= vblank_in;
            r_x_raw         <= w_x_raw_nxt;
            r_y_raw         <= w_y_raw_nxt;
            r_btn_raw       <= w_btn_raw_nxt;
            r_xpos          <= w_xpos_nxt;
            r_ypos          <= w_ypos_nxt;
            r_mouseleft     <= w_mouseleft_nxt;
            r_frame_tick    <= w_frame_tick_nxt;
            r_click_valid   <= w_click_valid_nxt;
            r_click_x       <= w_click_x_nxt;
            r_click_y       <= w_click_y_nxt;
            r_click_overrun <= w_click_overrun_nxt;
        end
    end

    assign xpos_out      = r_xpos;
    assign ypos_out      = r_ypos;
    assign mouseleft_out = r_mouseleft;
    assign frame_tick    = r_frame_tick;
    assign click_valid   = r_click_valid;
    assign click_x       = r_click_x;
    assign click_y       = r_click_y;
    assign click_overrun = r_click_overrun;

endmodule
